// File: rtl/core_local_interruptor_pkg.sv
// Shared address map, reset constants and byte-lane helper for the core-local interruptor.
package core_local_interruptor_pkg;

    localparam logic [31:0] CLINT_BASE        = 32'h0200_0000;
    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;
    localparam logic [63:0] MTIMECMP_RESET    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [15:0] off;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        acc;
        logic        wr;
    } clint_req_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/core_local_interruptor_mtime_counter.sv
// Prescaled 64-bit mtime counter with per-byte bus writes merged over the ticked value.
module clint_mtime_counter
    import core_local_interruptor_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int DIV_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [63:0] mtime,
    output logic [63:0] mtime_next
);
    logic [DIV_W-1:0] presc;
    logic             tick;
    logic [63:0]      mtime_inc;

    assign tick      = presc == DIV_W'(TICK_DIV - 1);
    assign mtime_inc = mtime + 64'(tick);

    // Written bytes override the incremented value; no carry crosses the written half.
    always_comb begin
        mtime_next = mtime_inc;
        if (wr_lo) mtime_next[31:0]  = merge_bytes(mtime_inc[31:0], wdata, be);
        if (wr_hi) mtime_next[63:32] = merge_bytes(mtime_inc[63:32], wdata, be);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + DIV_W'(1);
            mtime <= mtime_next;
        end
    end

endmodule

// File: rtl/core_local_interruptor.sv
// Memory-mapped msip / mtime / mtimecmp responder with single-cycle ready and interrupt outputs.
module core_local_interruptor
    import core_local_interruptor_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CLINT_BASE,
    parameter int          TICK_DIV  = 1,
    parameter int          DIV_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_select,
    input  logic        ren,
    input  logic        wen,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        msw_irq,
    output logic        mtimer_irq
);
    clint_req_t  req;
    logic [31:0] word_addr;
    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip;
    logic [31:0] rd_val;

    assign word_addr = addr & ~32'd3;
    assign sel       = word_addr[31:16] == BASE_ADDR[31:16];

    assign req.off   = word_addr[15:0];
    assign req.wdata = wdata;
    assign req.be    = byte_select;
    assign req.acc   = sel & (ren | wen);
    assign req.wr    = sel & wen;

    clint_mtime_counter #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_mtime (
        .clk        (clk),
        .reset      (reset),
        .wr_lo      (req.wr && req.off == CLINT_MTIME_LO),
        .wr_hi      (req.wr && req.off == CLINT_MTIME_HI),
        .wdata      (req.wdata),
        .be         (req.be),
        .mtime      (mtime),
        .mtime_next (mtime_next)
    );

    always_comb begin
        mtimecmp_next = mtimecmp;
        if (req.wr && req.off == CLINT_MTIMECMP_LO)
            mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], req.wdata, req.be);
        if (req.wr && req.off == CLINT_MTIMECMP_HI)
            mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], req.wdata, req.be);
    end

    always_comb begin
        rd_val = '0;
        case (req.off)
            CLINT_MSIP:        rd_val = {31'b0, msip};
            CLINT_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            CLINT_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            CLINT_MTIME_LO:    rd_val = mtime[31:0];
            CLINT_MTIME_HI:    rd_val = mtime[63:32];
            default:           rd_val = '0;
        endcase
    end

    // Response carries the pre-write value; compare uses the post-update registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msip       <= 1'b0;
            mtimecmp   <= MTIMECMP_RESET;
            ready      <= 1'b0;
            rdata      <= '0;
            mtimer_irq <= 1'b0;
        end else begin
            if (req.wr && req.off == CLINT_MSIP && req.be[0]) msip <= req.wdata[0];
            mtimecmp   <= mtimecmp_next;
            ready      <= req.acc;
            rdata      <= req.acc ? rd_val : '0;
            mtimer_irq <= mtime_next >= mtimecmp_next;
        end
    end

    assign msw_irq = msip;

endmodule

// File: tb/tb_core_local_interruptor.sv
// Randomised and directed bench comparing TICK_DIV=1 and TICK_DIV=4 instances against a behavioural model.
module tb_core_local_interruptor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic [3:0]  byte_select;
    logic        ren, wen;

    logic        sel_o[2], ready_o[2], msw_o[2], irq_o[2];
    logic [31:0] rdata_o[2];

    int unsigned n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    core_local_interruptor #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byte_select(byte_select),
        .ren(ren), .wen(wen), .sel(sel_o[0]), .rdata(rdata_o[0]), .ready(ready_o[0]),
        .msw_irq(msw_o[0]), .mtimer_irq(irq_o[0]));

    core_local_interruptor #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byte_select(byte_select),
        .ren(ren), .wen(wen), .sel(sel_o[1]), .rdata(rdata_o[1]), .ready(ready_o[1]),
        .msw_irq(msw_o[1]), .mtimer_irq(irq_o[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime[2] = '{64'd0, 64'd0};
    logic [63:0] m_cmp[2]   = '{'1, '1};
    logic        m_msip[2]  = '{1'b0, 1'b0};
    logic        m_ready[2] = '{1'b0, 1'b0};
    logic        m_irq[2]   = '{1'b0, 1'b0};
    logic [31:0] m_rdata[2] = '{32'd0, 32'd0};
    int unsigned m_cyc[2]   = '{0, 0};

    logic [15:0] mo;
    logic [31:0] mm;
    logic [63:0] nt, nc;
    logic        macc, mwr, mtk;
    int          mdiv;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [15:0] o);
        case (o)
            16'h0000: return {31'b0, m_msip[k]};
            16'h4000: return m_cmp[k][31:0];
            16'h4004: return m_cmp[k][63:32];
            16'hBFF8: return m_mtime[k][31:0];
            16'hBFFC: return m_mtime[k][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_mtime[k] = 0; m_cmp[k] = '1; m_msip[k] = 0;
                m_ready[k] = 0; m_irq[k] = 0; m_rdata[k] = 0; m_cyc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mdiv = (k == 0) ? 1 : 4;
                mo   = {addr[15:2], 2'b00};
                macc = (addr[31:16] == 16'h0200) && (ren || wen);
                mwr  = macc && wen;
                mm   = lane_mask(byte_select);
                m_ready[k] = macc;
                m_rdata[k] = macc ? mread(k, mo) : 32'd0;
                mtk = (m_cyc[k] % mdiv) == mdiv - 1;
                m_cyc[k]++;
                nt = m_mtime[k] + (mtk ? 64'd1 : 64'd0);
                nc = m_cmp[k];
                if (mwr) begin
                    case (mo)
                        16'h0000: if (byte_select[0]) m_msip[k] = wdata[0];
                        16'h4000: nc[31:0]  = (nc[31:0]  & ~mm) | (wdata & mm);
                        16'h4004: nc[63:32] = (nc[63:32] & ~mm) | (wdata & mm);
                        16'hBFF8: nt[31:0]  = (nt[31:0]  & ~mm) | (wdata & mm);
                        16'hBFFC: nt[63:32] = (nt[63:32] & ~mm) | (wdata & mm);
                        default: ;
                    endcase
                end
                m_mtime[k] = nt;
                m_cmp[k]   = nc;
                m_irq[k]   = nt >= nc;
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sel[%0d]", k),   {63'd0, sel_o[k]},   {63'd0, addr[31:16] == 16'h0200});
            chk($sformatf("ready[%0d]", k), {63'd0, ready_o[k]}, {63'd0, m_ready[k]});
            chk($sformatf("rdata[%0d]", k), {32'd0, rdata_o[k]}, {32'd0, m_rdata[k]});
            chk($sformatf("msw[%0d]", k),   {63'd0, msw_o[k]},   {63'd0, m_msip[k]});
            chk($sformatf("irq[%0d]", k),   {63'd0, irq_o[k]},   {63'd0, m_irq[k]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic r, input logic w);
        addr = a; wdata = d; byte_select = be; ren = r; wen = w;
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    localparam logic [15:0] OFFS [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                                         16'hBFFC, 16'h1000, 16'h0004};

    initial begin
        bit seen;
        reset = 1'b0; addr = '0; wdata = '0; byte_select = '0; ren = 1'b0; wen = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("mtime_after_10_div1", {32'd0, rdata_o[0]}, 64'd10);
        chk("mtime_after_10_div4", {32'd0, rdata_o[1]}, 64'd2);
        chk("ready_pulse", {63'd0, ready_o[0]}, 64'd1);
        do_req(32'h0200_4004, 0, 0, 1, 0);
        chk("mtimecmp_hi_reset", {32'd0, rdata_o[0]}, 64'hFFFF_FFFF);
        chk("irq_idle", {63'd0, irq_o[0]}, 64'd0);

        do_req(32'h0200_4004, 32'd0, 4'hF, 0, 1);
        do_req(32'h0200_4000, 32'd20, 4'hF, 0, 1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (irq_o[0]) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("irq_rise_seen", {63'd0, seen}, 64'd1);
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("mtime_at_irq_rise", {32'd0, rdata_o[0]}, 64'd20);
        do_req(32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 0, 1);
        chk("irq_drop", {63'd0, irq_o[0]}, 64'd0);

        do_req(32'h0200_0000, 32'd1, 4'b0001, 0, 1);
        chk("msip_set", {63'd0, msw_o[0]}, 64'd1);
        do_req(32'h0200_0000, 0, 0, 1, 0);
        chk("msip_read", {32'd0, rdata_o[0]}, 64'd1);
        do_req(32'h0200_0000, 32'd0, 4'b0001, 0, 1);
        chk("msip_clear", {63'd0, msw_o[0]}, 64'd0);
        do_req(32'h0200_0000, 32'd1, 4'b0010, 0, 1);
        chk("msip_wrong_lane", {63'd0, msw_o[0]}, 64'd0);

        do_req(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 0, 1);
        do_req(32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, 0, 1);
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("wrap_lo_pre", {32'd0, rdata_o[0]}, 64'hFFFF_FFFE);
        do_req(32'h0200_BFFC, 0, 0, 1, 0);
        chk("wrap_hi_pre", {32'd0, rdata_o[0]}, 64'hFFFF_FFFF);
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("wrap_lo_zero", {32'd0, rdata_o[0]}, 64'd0);
        do_req(32'h0200_BFFC, 0, 0, 1, 0);
        chk("wrap_hi_zero", {32'd0, rdata_o[0]}, 64'd0);
        do_req(32'h0200_BFF8, 32'h00AB_0000, 4'b0100, 0, 1);
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("partial_mtime_write", {32'd0, rdata_o[0]}, 64'h00AB_0003);

        do_req(32'h0200_4000, 32'h1234_5678, 4'hF, 1, 1);
        chk("rw_old_value", {32'd0, rdata_o[0]}, 64'hFFFF_FFFF);
        do_req(32'h0200_4000, 0, 0, 1, 0);
        chk("rw_new_value", {32'd0, rdata_o[0]}, 64'h1234_5678);
        do_req(32'h0300_0000, 0, 0, 1, 0);
        chk("off_window_sel", {63'd0, sel_o[0]}, 64'd0);
        chk("off_window_ready", {63'd0, ready_o[0]}, 64'd0);
        do_req(32'h0200_1000, 0, 0, 1, 0);
        chk("unmapped_ready", {63'd0, ready_o[0]}, 64'd1);
        chk("unmapped_rdata", {32'd0, rdata_o[0]}, 64'd0);

        for (int i = 0; i < 400; i++) begin
            addr        = {($urandom_range(0, 7) == 0) ? 16'h0300 : 16'h0200,
                           OFFS[$urandom_range(0, 6)] | 16'($urandom_range(0, 3))};
            wdata       = $urandom;
            byte_select = 4'($urandom);
            ren         = 1'($urandom);
            wen         = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        ren = 1'b0; wen = 1'b0;

        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        reset = 1'b0;
        #1;
        chk("reset_drops_ready", {63'd0, ready_o[0]}, 64'd0);
        chk("reset_rdata", {32'd0, rdata_o[0]}, 64'd0);
        chk("reset_irq", {63'd0, irq_o[1]}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        do_req(32'h0200_BFF8, 0, 0, 1, 0);
        chk("post_reset_mtime_div1", {32'd0, rdata_o[0]}, 64'd8);
        chk("post_reset_mtime_div4", {32'd0, rdata_o[1]}, 64'd2);
        do_req(32'h0200_4000, 0, 0, 1, 0);
        chk("post_reset_cmp_lo", {32'd0, rdata_o[1]}, 64'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_local_interruptor.md
Name: core_local_interruptor

Overview:
- Memory-mapped responder on the CPU data bus. Supplies the machine software interrupt (msip) and the machine timer interrupt (mtime/mtimecmp).
- Sits beside the data cache. Decodes a 64 KiB window and answers loads/stores with a single-cycle-latency ready pulse.
- Drives the cpu software_interrupt and timer_interrupt inputs.

Parameters:
- BASE_ADDR, 32'h0200_0000, window base; only addr[31:16] is compared.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).
- DIV_W, 8, width of the prescaler counter; TICK_DIV must be < 2^DIV_W.

Ports:
- clk  input  1  system clock (cpu_clk)
- reset  input  1  asynchronous, active-low reset
- addr  input  32  byte address from cpu data_addr
- wdata  input  32  store data (cpu data_out)
- byte_select  input  4  byte lane enables for stores
- ren  input  1  load request
- wen  input  1  store request
- sel  output  1  combinational: addr[31:16]==BASE_ADDR[31:16]
- rdata  output  32  load data, valid while ready=1
- ready  output  1  one-cycle response pulse
- msw_irq  output  1  machine software interrupt
- mtimer_irq  output  1  machine timer interrupt

Behaviour:
- Register map (offset = addr[15:0], word aligned; addr[1:0] ignored):
  - 0x0000: msip; bit0 R/W, bits 31:1 read 0.
  - 0x4000 / 0x4004: mtimecmp low / high word.
  - 0xBFF8 / 0xBFFC: mtime low / high word.
  - Any other offset in the window reads 0; writes to it are ignored.
- Reset (reset=0, async):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - ready=0, rdata=0, msw_irq=0, mtimer_irq=0.
- Request acceptance:
  - A request is accepted in any cycle with sel=1 and (ren|wen)=1.
  - There is no backpressure: every accepted cycle is independent, and back-to-back requests give back-to-back ready pulses.
  - ready is registered: high exactly one cycle after the accepted cycle, low otherwise.
  - rdata is registered with ready and holds the addressed register's value as sampled at the accepting edge, i.e. the pre-write value. rdata=0 when ready=0.
  - sel=0: no state change, ready stays 0.
- Writes:
  - Applied at the accepting edge, per byte lane. Lane i updates bits [8i+7:8i] when byte_select[i]=1.
  - byte_select=0 with wen: write ignored, ready still pulses.
  - ren and wen together: the write is performed and rdata returns the pre-write value.
- Timer:
  - The prescaler counts 0..TICK_DIV-1. mtime increments by 1 (64-bit, wraps 2^64-1 -> 0) on the edge where prescaler==TICK_DIV-1; the prescaler then returns to 0.
  - On a write to an mtime word in a tick cycle:
    - written bytes take wdata;
    - unwritten bytes of the written word, and the whole other word, take the incremented value;
    - no carry propagates from the written half.
  - mtimecmp writes never touch mtime.
- Interrupts:
  - mtimer_irq is registered: mtimer_irq <= (mtime_next >= mtimecmp_next), unsigned 64-bit. It therefore reflects a compare or mtimecmp write on the cycle after the update. It is level; it clears only when mtimecmp is raised above mtime or mtime wraps.
  - msw_irq = msip register bit0, direct register output.
- Reset mid-operation: everything returns to reset values immediately. A pending ready is dropped.

Decomposition:
- Shared package (config include):
  - CLINT_BASE;
  - offsets CLINT_MSIP=16'h0000, CLINT_MTIMECMP_LO=16'h4000, CLINT_MTIMECMP_HI=16'h4004, CLINT_MTIME_LO=16'hBFF8, CLINT_MTIME_HI=16'hBFFC;
  - MTIMECMP_RESET=64'hFFFF_FFFF_FFFF_FFFF.
- One natural sub-module: clint_mtime_counter, holding the prescaler, the 64-bit mtime, the byte-lane write merge and the tick output.
- Bus decode, msip, mtimecmp, compare and the response register stay in the top.

Test Plan:
- Reset release, TICK_DIV=1:
  - idle 10 cycles, then read 0xBFF8 -> ready one cycle later, rdata equals the cycle count since release (±0 per defined timing);
  - read 0x4004 -> 32'hFFFF_FFFF;
  - mtimer_irq=0.
- Write mtimecmp_hi=0 then mtimecmp_lo=20 -> mtimer_irq rises on the cycle after mtime reaches 20; writing mtimecmp_lo=32'hFFFF_FFFF drops it one cycle later.
- Write msip byte_select=4'b0001, wdata=1 -> msw_irq=1 next cycle; read 0x0000 returns 1; write 0 -> msw_irq=0. byte_select=4'b0010 with wdata=32'h1 -> no change.
- mtime wrap and partial write:
  - write mtime_hi=32'hFFFF_FFFF, mtime_lo=32'hFFFF_FFFE; two ticks later mtime=0;
  - byte_select=4'b0100 write to 0xBFF8 with wdata=32'h00AB_0000 -> byte 2 = 8'hAB, other bytes incremented.
- Bus handling:
  - ren and wen together on mtimecmp_lo -> rdata shows the old value, new value stored;
  - addr=0x0300_0000 -> sel=0, ready never asserted;
  - unmapped 0x0200_1000 read -> ready, rdata=0.
- Reset asserted in the cycle after an accepted read -> ready=0 immediately and all registers return to reset values; TICK_DIV=4 run shows mtime increments every 4 cycles.
